instr_loader: RTL

- Sequential instruction encoder and instruction-memory writer; the write-side counterpart of the main control decoder.
- Accepts symbolic instruction records (mnemonic code plus fields) over a valid/ready handshake.
- Encodes each record into a 32-bit MIPS word using the same opcode/funct assignments the decoder consumes.
- Writes the words to consecutive instruction-memory addresses; used by boot/test infrastructure to preload programs before the core runs.

---
 rtl/instr_loader_if.sv | 24 ++
 rtl/instr_loader.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/instr_loader_if.sv
// Symbolic instruction record channel (valid/ready) feeding instr_loader.
// The master drives a record plus in_last; the slave answers with in_ready.
interface instr_loader_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [4:0]  in_mnem;
    logic [4:0]  in_rs;
    logic [4:0]  in_rt;
    logic [4:0]  in_rd;
    logic [4:0]  in_shamt;
    logic [15:0] in_imm;
    logic [25:0] in_target;

    modport master (
        output in_valid, in_last, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_last, in_mnem, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
        output in_ready
    );
endinterface

// File: rtl/instr_loader.sv
// Encodes symbolic instruction records into MIPS words and writes them to consecutive
// instruction-memory addresses. Define INSTR_LOADER_ILLEGAL_TRAP_EN to abort on illegal mnemonics.
module instr_loader #(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    instr_loader_if.slave     rec,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wd,
    output logic              busy,
    output logic              done,
    output logic              overflow,
`ifdef INSTR_LOADER_ILLEGAL_TRAP_EN
    output logic              error_illegal,
`endif
    output logic [ADDR_W:0]   word_count
);

    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   CAP  = (ADDR_W+1)'(MAX_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH
    } state_e;

    typedef enum logic [4:0] {
        MN_ADD  = 5'd0,
        MN_SUB  = 5'd1,
        MN_AND  = 5'd2,
        MN_OR   = 5'd3,
        MN_SLT  = 5'd4,
        MN_SLL  = 5'd5,
        MN_SRL  = 5'd6,
        MN_JR   = 5'd7,
        MN_LW   = 5'd8,
        MN_SW   = 5'd9,
        MN_ADDI = 5'd10,
        MN_LUI  = 5'd11,
        MN_ORI  = 5'd12,
        MN_SLTI = 5'd13,
        MN_ANDI = 5'd14,
        MN_BEQ  = 5'd15,
        MN_BNE  = 5'd16,
        MN_J    = 5'd17,
        MN_JAL  = 5'd18
    } mnem_e;

    state_e            state;
    state_e            state_next;
    logic [ADDR_W-1:0] ptr;
    logic [31:0]       enc_word;
    logic              enc_legal;
    logic              write;
    logic              cap_hit;
    logic              trap;
    logic              at_cap;

    function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] funct);
        return {6'b000000, rs, rt, rd, sh, funct};
    endfunction

    function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    // Field forcing keeps don't-care fields zero so words match the decoder's canonical form.
    always_comb begin
        enc_word  = '0;
        enc_legal = 1'b1;
        case (rec.in_mnem)
            MN_ADD:  enc_word = rtype(rec.in_rs, rec.in_rt, rec.in_rd, 5'd0, 6'b100000);
            MN_SUB:  enc_word = rtype(rec.in_rs, rec.in_rt, rec.in_rd, 5'd0, 6'b100010);
            MN_AND:  enc_word = rtype(rec.in_rs, rec.in_rt, rec.in_rd, 5'd0, 6'b100100);
            MN_OR:   enc_word = rtype(rec.in_rs, rec.in_rt, rec.in_rd, 5'd0, 6'b100101);
            MN_SLT:  enc_word = rtype(rec.in_rs, rec.in_rt, rec.in_rd, 5'd0, 6'b101010);
            MN_SLL:  enc_word = rtype(5'd0, rec.in_rt, rec.in_rd, rec.in_shamt, 6'b000000);
            MN_SRL:  enc_word = rtype(5'd0, rec.in_rt, rec.in_rd, rec.in_shamt, 6'b000010);
            MN_JR:   enc_word = rtype(rec.in_rs, 5'd0, 5'd0, 5'd0, 6'b001000);
            MN_LW:   enc_word = itype(6'b100011, rec.in_rs, rec.in_rt, rec.in_imm);
            MN_SW:   enc_word = itype(6'b101011, rec.in_rs, rec.in_rt, rec.in_imm);
            MN_ADDI: enc_word = itype(6'b001000, rec.in_rs, rec.in_rt, rec.in_imm);
            MN_LUI:  enc_word = itype(6'b001111, 5'd0, rec.in_rt, rec.in_imm);
            MN_ORI:  enc_word = itype(6'b001101, rec.in_rs, rec.in_rt, rec.in_imm);
            MN_SLTI: enc_word = itype(6'b001010, rec.in_rs, rec.in_rt, rec.in_imm);
            MN_ANDI: enc_word = itype(6'b001100, rec.in_rs, rec.in_rt, rec.in_imm);
            MN_BEQ:  enc_word = itype(6'b000100, rec.in_rs, rec.in_rt, rec.in_imm);
            MN_BNE:  enc_word = itype(6'b000101, rec.in_rs, rec.in_rt, rec.in_imm);
            MN_J:    enc_word = {6'b000010, rec.in_target};
            MN_JAL:  enc_word = {6'b000011, rec.in_target};
            default: enc_legal = 1'b0;
        endcase
    end

    assign at_cap = (word_count == CAP);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        rec.in_ready = 1'b0;
        busy         = 1'b1;
        write        = 1'b0;
        cap_hit      = 1'b0;
        trap         = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (start) state_next = ST_LOAD;
            end
            ST_LOAD: begin
                rec.in_ready = 1'b1;
                if (rec.in_valid) begin
                    if (at_cap) begin
                        cap_hit    = 1'b1;
                        state_next = ST_FLUSH;
                    end
`ifdef INSTR_LOADER_ILLEGAL_TRAP_EN
                    else if (!enc_legal) begin
                        trap       = 1'b1;
                        state_next = ST_FLUSH;
                    end
`endif
                    else begin
                        write = 1'b1;
                        if (rec.in_last) state_next = ST_FLUSH;
                    end
                end
            end
            ST_FLUSH: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // Pointer and count advance at accept time, so word_count already includes the word on the bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wd    <= '0;
            ptr        <= BASE;
            word_count <= '0;
            overflow   <= 1'b0;
            done       <= 1'b0;
        end else begin
            imem_we <= write;
            done    <= (state == ST_FLUSH);
            if (state == ST_IDLE && start) begin
                ptr        <= BASE;
                word_count <= '0;
                overflow   <= 1'b0;
            end
            if (write) begin
                imem_addr  <= ptr;
                imem_wd    <= enc_legal ? enc_word : '0;
                ptr        <= ptr + 1'b1;
                word_count <= word_count + 1'b1;
            end
            if (cap_hit) overflow <= 1'b1;
        end
    end

`ifdef INSTR_LOADER_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            error_illegal <= 1'b0;
        end else if (state == ST_IDLE && start) begin
            error_illegal <= 1'b0;
        end else if (trap) begin
            error_illegal <= 1'b1;
        end
    end
`else
    logic unused_trap;
    assign unused_trap = trap;
`endif

endmodule
